// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq: sequential double-dabble converter, one input bit per clock.
// The result is a packed 4-digit BCD word. It is held stable between
// conversions so the downstream 7-segment driver can sample it on any cycle.
// Optional build macro: BIN2BCD_SAT_EN. When it is defined, inputs above 9999
// saturate to 16'h9999 and raise ovf. Otherwise the result is the input
// modulo 10000, and ovf is tied low.
module bin_to_bcd_seq #(
    parameter int IN_W = 14
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [IN_W-1:0] bin_in,
    output logic            busy,
    output logic            done,
    output logic [15:0]     bcd_out,
    output logic            ovf
);

    localparam int CNT_W = $clog2(IN_W + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [IN_W-1:0]   shreg_q, shreg_d;
    logic [15:0]       scratch_q, scratch_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [15:0]       bcd_q, bcd_d;

    // Combinational view of one SHIFT step
    logic [15:0]       scratch_adj;
    logic [15:0]       scratch_sh;
    logic [IN_W-1:0]   shreg_sh;
    logic              last_bit;

`ifdef BIN2BCD_SAT_EN
    logic              sat_q, sat_d;
    logic              ovf_q, ovf_d;
`endif

    // Add 3 to every BCD digit that is 5 or more, so the following shift
    // carries correctly into the next digit. The carry out of digit 3 is lost.
    function automatic logic [15:0] dabble_adjust(input logic [15:0] s);
        logic [15:0] r;
        r = s;
        for (int i = 0; i < 4; i++) begin
            if (s[i*4 +: 4] >= 4'd5) begin
                r[i*4 +: 4] = s[i*4 +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

    // Datapath for one conversion step: adjust the digits, then shift
    // {scratch, shreg} left by one bit.
    always_comb begin
        scratch_adj = dabble_adjust(scratch_q);
        scratch_sh  = {scratch_adj[14:0], shreg_q[IN_W-1]};
        shreg_sh    = {shreg_q[IN_W-2:0], 1'b0};
        last_bit    = (cnt_q == CNT_W'(1));
    end

    // Next-state logic: handshake sequencing, shift control and result capture
    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        scratch_d = scratch_q;
        cnt_d     = cnt_q;
        bcd_d     = bcd_q;
`ifdef BIN2BCD_SAT_EN
        sat_d     = sat_q;
        ovf_d     = ovf_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    shreg_d   = bin_in;
                    scratch_d = 16'h0000;
                    cnt_d     = CNT_W'(IN_W);
`ifdef BIN2BCD_SAT_EN
                    sat_d     = (32'(bin_in) > 32'd9999);
`endif
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                shreg_d   = shreg_sh;
                scratch_d = scratch_sh;
                cnt_d     = cnt_q - CNT_W'(1);
                if (last_bit) begin
`ifdef BIN2BCD_SAT_EN
                    bcd_d = sat_q ? 16'h9999 : scratch_sh;
                    ovf_d = sat_q;
`else
                    bcd_d = scratch_sh;
`endif
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any conversion in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            shreg_q   <= '0;
            scratch_q <= 16'h0000;
            cnt_q     <= '0;
            bcd_q     <= 16'h0000;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            scratch_q <= scratch_d;
            cnt_q     <= cnt_d;
            bcd_q     <= bcd_d;
        end
    end

`ifdef BIN2BCD_SAT_EN
    // Saturation flag latched at acceptance, and the overflow result register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sat_q <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            sat_q <= sat_d;
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`else
    assign ovf = 1'b0;
`endif

    // busy covers SHIFT and DONE. done is exactly the single DONE cycle.
    assign busy    = (state_q != IDLE);
    assign done    = (state_q == DONE);
    assign bcd_out = bcd_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
module tb_bin_to_bcd_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        start14 = 1'b0;
    logic [13:0] bin14   = '0;
    logic        busy14, done14, ovf14;
    logic [15:0] bcd14;

    logic        start4 = 1'b0;
    logic [3:0]  bin4   = '0;
    logic        busy4, done4, ovf4;
    logic [15:0] bcd4;

    logic        start10 = 1'b0;
    logic [9:0]  bin10   = '0;
    logic        busy10, done10, ovf10;
    logic [15:0] bcd10;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    bin_to_bcd_seq u14 (
        .clk(clk), .rst(rst), .start(start14), .bin_in(bin14),
        .busy(busy14), .done(done14), .bcd_out(bcd14), .ovf(ovf14)
    );

    bin_to_bcd_seq #(.IN_W(4)) u4 (
        .clk(clk), .rst(rst), .start(start4), .bin_in(bin4),
        .busy(busy4), .done(done4), .bcd_out(bcd4), .ovf(ovf4)
    );

    bin_to_bcd_seq #(.IN_W(10)) u10 (
        .clk(clk), .rst(rst), .start(start10), .bin_in(bin10),
        .busy(busy10), .done(done10), .bcd_out(bcd10), .ovf(ovf10)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One conversion on the default-width instance, measured from the accept edge
    task automatic conv14(input string tag, input logic [13:0] v,
                          input logic [15:0] eb, input logic eo);
        int n;
        bin14   = v;
        start14 = 1'b1;
        step();
        start14 = 1'b0;
        n = 0;
        while (done14 !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        check({tag, "_latency"}, n, 14);
        check({tag, "_bcd"}, bcd14, eb);
        check({tag, "_ovf"}, ovf14, eo);
        step();
        check({tag, "_done_fall"}, done14, 1'b0);
    endtask

    int n;
    int pulses;

    initial begin
        // Reset state of all instances
        step();
        step();
        check("rst_busy14", busy14, 1'b0);
        check("rst_done14", done14, 1'b0);
        check("rst_bcd14", bcd14, 16'h0000);
        check("rst_ovf14", ovf14, 1'b0);
        check("rst_bcd4", bcd4, 16'h0000);
        check("rst_bcd10", bcd10, 16'h0000);
        @(negedge clk);
        rst = 1'b0;
        step();

        // Test 1: 1234 with a cycle-by-cycle view of busy/done
        bin14   = 14'd1234;
        start14 = 1'b1;
        step();
        start14 = 1'b0;
        bin14   = 14'd0;
        for (int k = 1; k <= 13; k++) begin
            step();
            check($sformatf("t1_busy_e%0d", k), busy14, 1'b1);
            check($sformatf("t1_done_e%0d", k), done14, 1'b0);
            check($sformatf("t1_hold_e%0d", k), bcd14, 16'h0000);
        end
        step();
        check("t1_done_e14", done14, 1'b1);
        check("t1_busy_e14", busy14, 1'b1);
        check("t1_bcd", bcd14, 16'h1234);
        check("t1_ovf", ovf14, 1'b0);
        step();
        check("t1_done_e15", done14, 1'b0);
        check("t1_busy_e15", busy14, 1'b0);
        check("t1_bcd_held", bcd14, 16'h1234);

        // Test 2: boundary values
        conv14("b0", 14'd0, 16'h0000, 1'b0);
        conv14("b9", 14'd9, 16'h0009, 1'b0);
        conv14("b10", 14'd10, 16'h0010, 1'b0);
        conv14("b9999", 14'd9999, 16'h9999, 1'b0);

        // Test 3: out-of-range inputs
`ifdef BIN2BCD_SAT_EN
        conv14("o10000", 14'd10000, 16'h9999, 1'b1);
        conv14("o16383", 14'd16383, 16'h9999, 1'b1);
        conv14("o_clear", 14'd77, 16'h0077, 1'b0);
`else
        conv14("o10000", 14'd10000, 16'h0000, 1'b0);
        conv14("o16383", 14'd16383, 16'h6383, 1'b0);
`endif

        // Test 4: start held high, bin_in changed during SHIFT
        bin14   = 14'd4321;
        start14 = 1'b1;
        step();
        bin14   = 14'd5555;
        pulses  = 0;
        for (int k = 1; k <= 13; k++) begin
            step();
            if (done14 === 1'b1) pulses++;
        end
        check("t4_no_early_done", pulses, 0);
        step();
        check("t4_done_e14", done14, 1'b1);
        check("t4_bcd", bcd14, 16'h4321);
        pulses = 0;
        for (int k = 15; k <= 29; k++) begin
            step();
            if (done14 === 1'b1) pulses++;
            if (k == 15) check("t4_busy_e15", busy14, 1'b0);
            if (k == 16) check("t4_busy_e16", busy14, 1'b1);
        end
        check("t4_no_mid_done", pulses, 0);
        check("t4_bcd_held", bcd14, 16'h4321);
        step();
        check("t4_done_e30", done14, 1'b1);
        check("t4_bcd2", bcd14, 16'h5555);
        start14 = 1'b0;
        step();
        check("t4_idle", busy14, 1'b0);

        // Test 5: reset in the middle of a conversion
        bin14   = 14'd7777;
        start14 = 1'b1;
        step();
        start14 = 1'b0;
        for (int k = 1; k <= 6; k++) step();
        #2;
        rst = 1'b1;
        #1;
        check("t5_busy", busy14, 1'b0);
        check("t5_done", done14, 1'b0);
        check("t5_bcd", bcd14, 16'h0000);
        check("t5_ovf", ovf14, 1'b0);
        step();
        step();
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (done14 === 1'b1) pulses++;
        end
        check("t5_no_done", pulses, 0);
        check("t5_idle", busy14, 1'b0);
        conv14("t5_42", 14'd42, 16'h0042, 1'b0);

        // Test 6: narrower widths
        bin4   = 4'd15;
        start4 = 1'b1;
        step();
        start4 = 1'b0;
        n = 0;
        while (done4 !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        check("w4_latency", n, 4);
        check("w4_bcd", bcd4, 16'h0015);
        check("w4_ovf", ovf4, 1'b0);

        bin10   = 10'd1023;
        start10 = 1'b1;
        step();
        start10 = 1'b0;
        n = 0;
        while (done10 !== 1'b1 && n < 30) begin
            step();
            n++;
        end
        check("w10_latency", n, 10);
        check("w10_bcd", bcd10, 16'h1023);
        check("w10_ovf", ovf10, 1'b0);
        step();
        check("w10_done_fall", done10, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
